// File: rtl/mem_pkg.sv
// Shared types and constants for the memory access controller.
// Imported by the interface, decoder and controller.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RELEASE
    } state_e;

    localparam logic CELL_READ  = 1'b1;
    localparam logic CELL_WRITE = 1'b0;

    // Wide enough for write hold counts up to 15.
    localparam int CNT_W = 4;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/response handshake bundle for mem_access_ctrl.
// master issues requests, slave is the controller.
interface mem_access_ctrl_if #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 4
);
    logic              req_valid;
    logic              req_ready;
    logic              req_rw;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;

    modport master (
        output req_valid, req_rw, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_rw, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/addr_decoder.sv
// Binary to one-hot word select decoder with enable.
// Output is all-zero when disabled.
module addr_decoder #(
    parameter int ADDR_W = 2
) (
    input  logic                 en,
    input  logic [ADDR_W-1:0]    addr,
    output logic [2**ADDR_W-1:0] onehot
);

    // One bit set for the addressed word when enabled.
    always_comb begin
        onehot = '0;
        if (en) onehot[addr] = 1'b1;
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequencer driving select/RW/input_bit of a latch-based bitcell array.
// Data lines only move while every word select is low.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W       = 2,
    parameter int DATA_W       = 4,
    parameter int WRITE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_access_ctrl_if.slave     bus,
    output logic [2**ADDR_W-1:0] word_select,
    output logic                 cell_rw,
    output logic [DATA_W-1:0]    cell_in,
    input  logic [DATA_W-1:0]    cell_out
);

    localparam int WORDS = 2**ADDR_W;

    state_e             state_q;
    state_e             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [WORDS-1:0]   sel_d;
    logic               sel_en;
    logic               rsp_q;
    logic [DATA_W-1:0]  rdata_q;
    logic               accept;
    logic               last_beat;

    assign bus.req_ready = (state_q == IDLE) && !rst;
    assign bus.rsp_valid = rsp_q;
    assign bus.rsp_rdata = rdata_q;

    assign accept    = bus.req_valid && bus.req_ready;
    assign last_beat = (cell_rw == CELL_READ) || (cnt_q == CNT_W'(1));
    assign sel_en    = (state_d == ACCESS);

    addr_decoder #(
        .ADDR_W (ADDR_W)
    ) u_dec (
        .en     (sel_en),
        .addr   (addr_q),
        .onehot (sel_d)
    );

    // Next-state: one pass through SETUP/ACCESS/RELEASE per request.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (last_beat) state_d = RELEASE;
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, hold counter and registered array/response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            word_select <= '0;
            cell_rw     <= CELL_READ;
            cell_in     <= '0;
            rsp_q       <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            word_select <= sel_d;
            rsp_q       <= (state_q == ACCESS) && (state_d == RELEASE);
            if (accept) begin
                addr_q  <= bus.req_addr;
                cell_rw <= bus.req_rw;
                cell_in <= (bus.req_rw == CELL_WRITE) ? bus.req_wdata : '0;
            end
            if (state_q == SETUP) begin
                cnt_q <= CNT_W'(WRITE_CYCLES);
            end else if (state_q == ACCESS) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (state_q == ACCESS && cell_rw == CELL_READ) begin
                rdata_q <= cell_out;
            end
            if (state_q == RELEASE) begin
                cell_rw <= CELL_READ;
                cell_in <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench: controller plus a 4x4 latch bitcell array.
// Checks timing, data, array-side safety and mid-access reset.
module tb_mem_access_ctrl;

    localparam int WC = 3;

    logic       clk;
    logic       rst;
    logic [3:0] word_select;
    logic       cell_rw;
    logic [3:0] cell_in;
    logic [3:0] cell_out;
    logic [3:0] word_out [4];

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] pat [4];
    logic [3:0] last_rd;

    mem_access_ctrl_if #(.ADDR_W(2), .DATA_W(4)) bus ();

    mem_access_ctrl #(
        .ADDR_W       (2),
        .DATA_W       (4),
        .WRITE_CYCLES (WC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .word_select (word_select),
        .cell_rw     (cell_rw),
        .cell_in     (cell_in),
        .cell_out    (cell_out)
    );

    for (genvar w = 0; w < 4; w++) begin : g_word
        logic [3:0] q;
        always_latch begin
            if (word_select[w] && !cell_rw) q <= cell_in;
        end
        assign word_out[w] = (word_select[w] && cell_rw) ? q : 4'b0;
    end

    assign cell_out = word_out[0] | word_out[1] | word_out[2] | word_out[3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    logic       armed = 1'b0;
    logic [3:0] ws_p;
    logic       rw_p;
    logic [3:0] in_p;

    always @(negedge clk) begin
        if (armed) begin
            check("safe_order",
                  {31'b0, ((cell_rw !== rw_p) || (cell_in !== in_p)) &&
                          ((ws_p != 4'b0) || (word_select != 4'b0))},
                  32'd0);
            check("ws_onehot", {31'b0, $countones(word_select) > 1}, 32'd0);
        end
        ws_p = word_select;
        rw_p = cell_rw;
        in_p = cell_in;
    end

    // Entered and left on a negedge with the controller idle.
    task automatic access(input logic rw, input logic [1:0] a,
                          input logic [3:0] wd, input logic [3:0] exp_rd);
        int lat;
        int t;
        logic [3:0] oh;
        lat = rw ? 3 : 2 + WC;
        oh  = 4'b0001 << a;
        bus.req_valid = 1'b1;
        bus.req_rw    = rw;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        t = 0;
        while (!bus.req_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("hs_wait", {31'b0, t < 20}, 32'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_rw    = ~rw;
        bus.req_addr  = ~a;
        bus.req_wdata = ~wd;
        for (int k = 1; k <= lat + 1; k++) begin
            if (k > 1) @(negedge clk);
            check("word_select", {28'b0, word_select},
                  {28'b0, (k >= 2 && k <= lat - 1) ? oh : 4'b0});
            check("rsp_valid", {31'b0, bus.rsp_valid}, {31'b0, k == lat});
            check("req_ready", {31'b0, bus.req_ready},
                  {31'b0, k == lat + 1});
            if (k == lat) begin
                if (rw) last_rd = exp_rd;
                check("rsp_rdata", {28'b0, bus.rsp_rdata}, {28'b0, last_rd});
            end
        end
    endtask

    initial begin
        pat[0] = 4'h1;
        pat[1] = 4'h2;
        pat[2] = 4'h4;
        pat[3] = 4'h8;
        last_rd = 4'h0;

        rst = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_rw    = 1'b0;
        bus.req_addr  = 2'd1;
        bus.req_wdata = 4'hf;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'b0, bus.req_ready}, 32'd0);
        check("rst_ws", {28'b0, word_select}, 32'd0);
        check("rst_rw", {31'b0, cell_rw}, 32'd1);
        check("rst_in", {28'b0, cell_in}, 32'd0);
        check("rst_rsp", {31'b0, bus.rsp_valid}, 32'd0);
        check("rst_rdata", {28'b0, bus.rsp_rdata}, 32'd0);
        rst = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("post_rst_ready", {31'b0, bus.req_ready}, 32'd1);
        check("post_rst_ws", {28'b0, word_select}, 32'd0);
        armed = 1'b1;

        access(1'b0, 2'd2, 4'b1010, 4'h0);
        access(1'b1, 2'd2, 4'h0, 4'b1010);

        for (int i = 0; i < 4; i++) access(1'b0, 2'(i), pat[i], 4'h0);
        for (int i = 0; i < 4; i++) access(1'b1, 2'(i), 4'h0, pat[i]);

        for (int i = 0; i < 16; i++) begin
            if (i % 4 == 0) begin
                bus.req_valid = 1'b1;
                bus.req_rw    = 1'b1;
                bus.req_addr  = 2'(i / 4);
            end
            check("b2b_ready", {31'b0, bus.req_ready}, {31'b0, i % 4 == 0});
            check("b2b_rsp", {31'b0, bus.rsp_valid}, {31'b0, i % 4 == 3});
            if (i % 4 == 3)
                check("b2b_rdata", {28'b0, bus.rsp_rdata}, {28'b0, pat[i / 4]});
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        last_rd = pat[3];

        bus.req_valid = 1'b1;
        bus.req_rw    = 1'b1;
        bus.req_addr  = 2'd3;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("abort_ws_active", {28'b0, word_select}, 32'h8);
        rst = 1'b1;
        @(negedge clk);
        check("abort_ws", {28'b0, word_select}, 32'd0);
        check("abort_rw", {31'b0, cell_rw}, 32'd1);
        check("abort_in", {28'b0, cell_in}, 32'd0);
        check("abort_rsp", {31'b0, bus.rsp_valid}, 32'd0);
        check("abort_ready", {31'b0, bus.req_ready}, 32'd0);
        rst = 1'b0;
        last_rd = 4'h0;
        @(negedge clk);
        check("abort_rsp2", {31'b0, bus.rsp_valid}, 32'd0);
        check("abort_ready2", {31'b0, bus.req_ready}, 32'd1);

        access(1'b0, 2'd0, 4'h5, 4'h0);
        access(1'b1, 2'd0, 4'h0, 4'h5);
        access(1'b1, 2'd3, 4'h0, 4'h8);
        access(1'b1, 2'd1, 4'h0, 4'h2);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
